// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish right after accept.
module div_unit #(
    parameter int ARCH_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [1:0]          op,
    input  logic [ARCH_LEN-1:0] dividend,
    input  logic [ARCH_LEN-1:0] divisor,
    input  logic                flush,
    output logic [ARCH_LEN-1:0] result,
    output logic                done,
    output logic                stall_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [5:0]          LAST_ITER = 6'(ARCH_LEN - 1);
    localparam logic [ARCH_LEN-1:0] MIN_NEG   = {1'b1, {(ARCH_LEN-1){1'b0}}};

    logic [1:0]          state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic                sa_q, sa_d;
    logic                sb_q, sb_d;
    logic [ARCH_LEN-1:0] dvsr_q, dvsr_d;
    logic [ARCH_LEN-1:0] rem_q, rem_d;
    logic [ARCH_LEN-1:0] quot_q, quot_d;
    logic [ARCH_LEN-1:0] result_q, result_d;

    logic [ARCH_LEN:0]   shifted;
    logic [ARCH_LEN:0]   trial;
    logic                fits;
    logic [ARCH_LEN-1:0] rem_next, quot_next, rem_fin, quot_fin;
    logic                is_signed;

    // Dividend bits are shifted out of quot_q's MSB while quotient bits enter at its LSB.
    assign shifted   = {rem_q, quot_q[ARCH_LEN-1]};
    assign trial     = shifted - {1'b0, dvsr_q};
    assign fits      = ~trial[ARCH_LEN];
    assign rem_next  = fits ? trial[ARCH_LEN-1:0] : shifted[ARCH_LEN-1:0];
    assign quot_next = {quot_q[ARCH_LEN-2:0], fits};
    assign quot_fin  = (sa_q ^ sb_q) ? -quot_next : quot_next;
    assign rem_fin   = sa_q ? -rem_next : rem_next;
    assign is_signed = ~op[0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dvsr_d   = dvsr_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    op_d = op;
                    sa_d = is_signed & dividend[ARCH_LEN-1];
                    sb_d = is_signed & divisor[ARCH_LEN-1];
                    if (divisor == '0) begin
                        result_d = op[1] ? dividend : '1;
                        state_d  = S_DONE;
                    end else if (is_signed && dividend == MIN_NEG && divisor == '1) begin
                        result_d = op[1] ? '0 : MIN_NEG;
                        state_d  = S_DONE;
                    end else begin
                        quot_d  = (is_signed & dividend[ARCH_LEN-1]) ? -dividend : dividend;
                        dvsr_d  = (is_signed & divisor[ARCH_LEN-1]) ? -divisor : divisor;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d  = rem_next;
                quot_d = quot_next;
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) begin
                    result_d = op_q[1] ? rem_fin : quot_fin;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over both acceptance and completion.
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dvsr_q   <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dvsr_q   <= dvsr_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            result_q <= result_d;
        end
    end

    assign result    = result_q;
    assign done      = (state_q == S_DONE);
    assign stall_out = ~rst & (((state_q == S_IDLE) & valid_in & ~flush) | (state_q == S_CALC));

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter ARCH_LEN, default 32 (from constants_pkg), operand/result width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 valid_in  input  1  execute stage holds a valid DIV/DIVU/REM/REMU instruction.
REQ-005 op  input  2  func3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 dividend  input  ARCH_LEN  rs1 value.
REQ-007 divisor  input  ARCH_LEN  rs2 value.
REQ-008 flush  input  1  kill in-flight operation (branch mispredict/exception).
REQ-009 result  output  ARCH_LEN  registered quotient or remainder; the execute stage places it in dst_reg_data toward memory_stage.
REQ-010 done  output  1  result valid this cycle; single-cycle pulse.
REQ-011 stall_out  output  1  freeze fetch/decode/execute while the divide is unfinished.

Function
REQ-012 States: IDLE, CALC, DONE; 6-bit iteration counter; latched op, operand signs, |dividend|, |divisor|, partial remainder, quotient.
REQ-013 IDLE: valid_in=1 and flush=0 accepts the operation at the clock edge and latches all inputs; subsequent input changes are ignored until return to IDLE.
REQ-014 Divisor==0 at accept: go to DONE; quotient = all ones (0xFFFFFFFF), remainder = dividend, for signed and unsigned ops.
REQ-015 Signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF) at accept: go to DONE; quotient = 0x80000000, remainder = 0.
REQ-016 Otherwise: go to CALC, counter = 0; signed ops latch absolute values (0x80000000 stays 0x80000000, treated unsigned); unsigned ops latch raw values.
REQ-017 CALC: radix-2 restoring division, one quotient bit per cycle, MSB first, ARCH_LEN+1-bit trial subtraction; counter increments each cycle; after the ARCH_LEN-th iteration go to DONE.
REQ-018 DONE: result registered on the CALC->DONE edge; signed op: quotient negated iff operand signs differ; remainder takes the dividend's sign; REM/REMU select the remainder, DIV/DIVU the quotient.
REQ-019 DONE lasts exactly one cycle with done=1, then IDLE unconditionally; valid_in during DONE is not accepted.
REQ-020 Latency: accept edge in cycle 0; normal ops show done=1 in cycle ARCH_LEN+1 (33); special cases in cycle 1.
REQ-021 stall_out = (IDLE & valid_in & ~flush) | CALC; 0 in DONE, so the pipeline advances in the done cycle.
REQ-022 flush=1 in any state: next state IDLE, done=0 next cycle, no result update; flush overrides valid_in in IDLE and completion in CALC.
REQ-023 result holds its last value outside DONE; consumers sample it only when done=1.
REQ-024 Back-to-back divides: the second instruction is accepted in the IDLE cycle after DONE; no extra bubble.

Reset
REQ-025 rst=1 forces state IDLE, counter 0, result 0, done 0 immediately, regardless of clock.
REQ-026 stall_out is 0 while rst=1; reset mid-CALC discards the operation, and no done pulse follows.
REQ-027 First accept is possible on the first rising edge after rst deasserts.

Verification
REQ-028 DIVU 100/7 -> stall_out=1 for cycles 0..32, done=1 in cycle 33, result=14; REMU same operands -> 2.
REQ-029 DIV 0xFFFFFFF9 (-7)/2 -> result 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
REQ-030 DIVU 5/0 -> done in cycle 1, result 0xFFFFFFFF; REMU 5/0 -> 5; DIV -5/0 -> 0xFFFFFFFF.
REQ-031 DIV 0x80000000/0xFFFFFFFF -> done in cycle 1, result 0x80000000; REM -> 0.
REQ-032 Flush in cycle 10 of CALC -> IDLE in cycle 11, no done pulse, stall_out=0; the next divide completes normally.
REQ-033 rst pulse mid-CALC (between edges) -> outputs reset immediately, no done pulse; back-to-back DIVU 9/3 then 8/2 -> results 3 and 4 with done 34 cycles apart.
